// File: rtl/timer_share_arb_if.sv
// Request/grant bundle between the requesting sub-blocks and the shared interval timer.
interface timer_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 26,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic [CNT_W-1:0]         count;

  modport master (
    output req, len,
    input  gnt, done, busy, cur_id, count
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, cur_id, count
  );
endinterface

// File: rtl/timer_share_arb.sv
// Round-robin arbiter sharing one countdown-style interval counter among NUM_REQ requesters.
module timer_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 26,
  parameter int ID_W    = 3
) (
  input logic             clk,
  input logic             rst,
  timer_share_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                busy_q;
  logic [ID_W-1:0]     cur_id_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    len_q;
  logic [ID_W-1:0]     rr_ptr;

  logic                found;
  logic [ID_W-1:0]     win_id;
  logic [NUM_REQ-1:0]  win_oh;
  logic [CNT_W-1:0]    win_len;
  logic [ID_W-1:0]     nxt_ptr;
  logic                req_held;

  // Two passes: first indices >= rr_ptr, then wrap to the lowest index.
  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    win_len = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req[i] && (pass == 1 || ID_W'(i) >= rr_ptr)) begin
          found   = 1'b1;
          win_id  = ID_W'(i);
          win_oh  = NUM_REQ'(1) << i;
          win_len = bus.len[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  assign nxt_ptr  = (cur_id_q == ID_W'(NUM_REQ-1)) ? '0 : cur_id_q + 1'b1;
  assign req_held = |(bus.req & gnt_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cur_id_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            len_q    <= win_len;
            count_q  <= '0;
            gnt_q    <= win_oh;
            cur_id_q <= win_id;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!req_held) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end else if (count_q == len_q) begin
            done_q <= gnt_q;
            state  <= FIN;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        FIN: begin
          done_q <= '0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cur_id = cur_id_q;
  assign bus.count  = count_q;

endmodule

// File: doc/timer_share_arb.md
Name: timer_share_arb

Overview:
- Round-robin arbiter and sequencer for one shared programmable countdown timer, the same count-to-terminal datapath as the clock divider.
- Up to NUM_REQ game or display sub-blocks request a timed interval of a given length.
- The block grants the single counter to one requester at a time, runs the interval, and returns a one-cycle done pulse.
- It replaces per-requester divider instances with one shared counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 26, counter and interval-length width.
- ID_W, 3, width of cur_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low (rst==0 at a posedge resets).
- req  input  NUM_REQ  per-requester interval request, level.
- len  input  NUM_REQ*CNT_W  packed interval lengths; slice i = len[i*CNT_W +: CNT_W].
- gnt  output  NUM_REQ  one-hot grant, zero when idle.
- done  output  NUM_REQ  one-hot, one-cycle interval-complete pulse.
- busy  output  1  high while an interval is granted.
- cur_id  output  ID_W  index of the current or last winner.
- count  output  CNT_W  live counter value, for debug and display.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, gnt=0, done=0, busy=0, cur_id=0, count=0, rr_ptr=0, len_q=0. Reset mid-interval aborts it immediately with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - If req!=0 at posedge: winner = first asserted index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Same edge: len_q <= len slice of winner, count <= 0, gnt <= onehot(winner), cur_id <= winner, busy <= 1, state <= RUN.
  - If req==0: remain in IDLE; all outputs hold their idle values.
- RUN, at each posedge:
  - If req[cur_id]==0: abort. gnt <= 0, busy <= 0, no done, rr_ptr <= cur_id+1 mod NUM_REQ, state <= IDLE.
  - Else if count==len_q: done <= onehot(cur_id), state <= FIN; count holds.
  - Else: count <= count+1.
  - Abort has priority over terminal count on the same edge.
- FIN, at the next posedge: done <= 0, gnt <= 0, busy <= 0, rr_ptr <= cur_id+1 mod NUM_REQ, state <= IDLE.
- Latency, with the request sampled at posedge k:
  - gnt is high from k to k+len+2.
  - done is high for exactly the cycle after posedge k+len+1, while gnt is still high.
  - The next grant occurs no earlier than posedge k+len+3.
  - len=0 gives done after posedge k+1.
- len is sampled only at the grant edge. Changes to len afterwards, or to other requesters' slices, have no effect on the running interval.
- Counter arithmetic is unsigned CNT_W. count never exceeds len_q, so no wrap. len = 2^CNT_W-1 is legal.
- Requesters must drop req on seeing done.
  - If req stays high through FIN, it is treated as a new request in IDLE.
  - Because rr_ptr has advanced past it, any other pending requester wins first.
- Requests arriving during RUN or FIN are not lost as long as the level is held. They are arbitrated at the next IDLE edge.
- Invariants: gnt and done are never multi-hot; done is never asserted without the matching gnt bit; busy == (gnt!=0).
- cur_id holds the last winner while in IDLE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, count=0, cur_id=0 on every cycle.
- Single request: req=4'b0100, len[2]=5 sampled at edge k -> gnt=4'b0100 from k to k+7; done=4'b0100 only in the cycle after k+6; count reaches 5; busy falls after k+7.
- Round-robin fairness: req=4'b1111 held continuously, all len=2 -> winners in order 0,1,2,3,0; each grant lasts 4 cycles, with one IDLE cycle between grants.
- Zero length and maximum value: len[1]=0 -> done after grant edge +1. Set CNT_W=4 with len[3]=15 -> done after grant edge +16 with no wrap of count.
- Abort: req[0] dropped when count==3 with len[0]=10 -> gnt=0 next cycle, no done pulse; a pending req[1] is granted on the following edge.
- Reset mid-RUN and len change: change len[2] from 8 to 1 two cycles after the grant -> interval still ends at count==8. Then pull rst=0 during a fresh RUN -> all outputs 0 next cycle and no done pulse.
